// File: rtl/wb_stage_if.sv
// Write-back stage bus: MEM-stage inputs, MDU write offer and register-file write port.
// The design side uses the slave modport; the environment drives through master.
interface wb_stage_if #(
    parameter int WIDTH   = 32,
    parameter int REGADDR = 5
);
    logic               mem_valid;
    logic               mem_reg_wrt;
    logic               mem_to_reg;
    logic [WIDTH-1:0]   mem_alu;
    logic [WIDTH-1:0]   mem_rdata;
    logic [REGADDR-1:0] mem_reg;
    logic [1:0]         ld_size;
    logic               ld_unsigned;
    logic               stall;
    logic               flush;
    logic               mdu_valid;
    logic [REGADDR-1:0] mdu_reg;
    logic [WIDTH-1:0]   mdu_data;
    logic               mdu_ready;
    logic               wb_stall_req;
    logic               reg_wrt;
    logic [REGADDR-1:0] wrt_reg;
    logic [WIDTH-1:0]   wrt_dt;
    logic [31:0]        retired_cnt;

    modport master (
        output mem_valid, mem_reg_wrt, mem_to_reg, mem_alu, mem_rdata,
        output mem_reg, ld_size, ld_unsigned, stall, flush,
        output mdu_valid, mdu_reg, mdu_data,
        input  mdu_ready, wb_stall_req, reg_wrt, wrt_reg, wrt_dt,
        input  retired_cnt
    );

    modport slave (
        input  mem_valid, mem_reg_wrt, mem_to_reg, mem_alu, mem_rdata,
        input  mem_reg, ld_size, ld_unsigned, stall, flush,
        input  mdu_valid, mdu_reg, mdu_data,
        output mdu_ready, wb_stall_req, reg_wrt, wrt_reg, wrt_dt,
        output retired_cnt
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: load extraction, MEM/MDU write merge through a 1-entry
// pending buffer with starvation stall request, and a retired-instruction counter.
module wb_stage #(
    parameter int WIDTH        = 32,
    parameter int REGADDR      = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_stage_if.slave  bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic               pend_q, pend_d;
    logic [REGADDR-1:0] pend_reg_q, pend_reg_d;
    logic [WIDTH-1:0]   pend_data_q, pend_data_d;
    logic [CW-1:0]      wait_q, wait_d;
    logic               wr_q, wr_d;
    logic [REGADDR-1:0] wreg_q, wreg_d;
    logic [WIDTH-1:0]   wdt_q, wdt_d;
    logic [31:0]        cnt_q, cnt_d;

    logic               cap, pipe_wr, drain, accept;
    logic [7:0]         byte_v;
    logic [15:0]        half_v;
    logic [WIDTH-1:0]   load_v, wb_data;

    assign cap     = bus.mem_valid && !bus.stall && !bus.flush;
    assign pipe_wr = cap && bus.mem_reg_wrt;
    assign drain   = pend_q && !pipe_wr;
    assign accept  = bus.mdu_valid && !pend_q;

    // Big-endian lanes: address 0 is the most significant byte.
    always_comb begin
        byte_v = '0;
        case (bus.mem_alu[1:0])
            2'd0:    byte_v = bus.mem_rdata[WIDTH-1 -: 8];
            2'd1:    byte_v = bus.mem_rdata[WIDTH-9 -: 8];
            2'd2:    byte_v = bus.mem_rdata[WIDTH-17 -: 8];
            default: byte_v = bus.mem_rdata[WIDTH-25 -: 8];
        endcase
    end

    assign half_v = bus.mem_alu[1] ? bus.mem_rdata[15:0]
                                   : bus.mem_rdata[WIDTH-1 -: 16];

    always_comb begin
        load_v = bus.mem_rdata;
        case (bus.ld_size)
            2'b01: begin
                if (bus.ld_unsigned)
                    load_v = {{(WIDTH-16){1'b0}}, half_v};
                else
                    load_v = {{(WIDTH-16){half_v[15]}}, half_v};
            end
            2'b10: begin
                if (bus.ld_unsigned)
                    load_v = {{(WIDTH-8){1'b0}}, byte_v};
                else
                    load_v = {{(WIDTH-8){byte_v[7]}}, byte_v};
            end
            default: load_v = bus.mem_rdata;
        endcase
    end

    assign wb_data = bus.mem_to_reg ? load_v : bus.mem_alu;

    always_comb begin
        pend_d      = pend_q;
        pend_reg_d  = pend_reg_q;
        pend_data_d = pend_data_q;
        wait_d      = wait_q;
        wr_d        = 1'b0;
        wreg_d      = wreg_q;
        wdt_d       = wdt_q;
        cnt_d       = cap ? cnt_q + 32'd1 : cnt_q;
        unique case (1'b1)
            pipe_wr: begin
                wr_d   = |bus.mem_reg;
                wreg_d = bus.mem_reg;
                wdt_d  = wb_data;
                if (pend_q && wait_q != LIMIT)
                    wait_d = wait_q + CW'(1);
            end
            drain: begin
                wr_d   = |pend_reg_q;
                wreg_d = pend_reg_q;
                wdt_d  = pend_data_q;
                pend_d = 1'b0;
                wait_d = '0;
            end
            default: ;
        endcase
        // Only reachable while empty, so it never collides with a drain.
        if (accept) begin
            pend_d      = 1'b1;
            pend_reg_d  = bus.mdu_reg;
            pend_data_d = bus.mdu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= 1'b0;
            pend_reg_q  <= '0;
            pend_data_q <= '0;
            wait_q      <= '0;
            wr_q        <= 1'b0;
            wreg_q      <= '0;
            wdt_q       <= '0;
            cnt_q       <= '0;
        end else begin
            pend_q      <= pend_d;
            pend_reg_q  <= pend_reg_d;
            pend_data_q <= pend_data_d;
            wait_q      <= wait_d;
            wr_q        <= wr_d;
            wreg_q      <= wreg_d;
            wdt_q       <= wdt_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.mdu_ready    = !pend_q;
    assign bus.wb_stall_req = pend_q && (wait_q == LIMIT);
    assign bus.reg_wrt      = wr_q;
    assign bus.wrt_reg      = wreg_q;
    assign bus.wrt_dt       = wdt_q;
    assign bus.retired_cnt  = cnt_q;
endmodule
